// File: rtl/pwm_regs_pkg.sv
// Shared register-map constants and helpers for the PWM/timer register file.
package pwm_regs_pkg;

  localparam int REG_CTRL    = 0;
  localparam int REG_PERIOD  = 1;
  localparam int REG_DIV     = 2;
  localparam int REG_DC      = 3;
  localparam int REGS_PER_CH = 4;

  // Channel lock lives in the MSB of the ctrl register.
  function automatic int lock_bit(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int status_addr(input int ch_num);
    return REGS_PER_CH * ch_num;
  endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Combinational byte-lane merge: lane k takes new data when sel[k] is set, else keeps old.
module wb_byte_merge #(
  parameter  int DATA_W = 16,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] o_merged
);

  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_lane
    assign o_merged[gi*8 +: 8] = i_sel[gi] ? i_new[gi*8 +: 8] : i_old[gi*8 +: 8];
  end

endmodule

// File: rtl/wb_regfile_mc.sv
// Multi-channel Wishbone B4 classic register file with W1C interrupt status.
// Optional channel write lock selected by WB_WRITE_PROTECT_EN.
module wb_regfile_mc
  import pwm_regs_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int CH_NUM = 3,
  parameter  int ADR_W  = 16,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic                     i_wb_clk,
  input  logic                     i_wb_rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [ADR_W-1:0]         i_wb_adr,
  input  logic [SEL_W-1:0]         i_wb_sel,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic [CH_NUM-1:0]        i_ch_irq,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic [DATA_W-1:0]        o_wb_data,
  output logic [CH_NUM*DATA_W-1:0] o_ch_ctrl,
  output logic [CH_NUM*DATA_W-1:0] o_ch_period,
  output logic [CH_NUM*DATA_W-1:0] o_ch_div,
  output logic [CH_NUM*DATA_W-1:0] o_ch_dc,
  output logic                     o_irq
);

  localparam int STATUS_ADR = status_addr(CH_NUM);
  localparam int NREGS      = CH_NUM * REGS_PER_CH;
`ifdef WB_WRITE_PROTECT_EN
  localparam int LOCK_BIT   = lock_bit(DATA_W);
`endif

  logic [DATA_W-1:0] regs_q [CH_NUM][REGS_PER_CH];
  logic [DATA_W-1:0] regs_d [CH_NUM][REGS_PER_CH];
  logic [CH_NUM-1:0] flags_q, flags_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              irq_q, irq_d;

  logic              accept;
  logic              hit_reg;
  logic              hit_status;
  logic              locked;
  logic [NREGS-1:0]  hit_vec;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] merged;
  logic [CH_NUM-1:0] clr_bits;
  logic              reg_wr;
  logic              status_wr;

  // Address decode and current value of the addressed register.
  always_comb begin
    accept     = i_wb_cyc & i_wb_stb & ~ack_q & ~err_q;
    hit_status = (i_wb_adr == ADR_W'(STATUS_ADR));
    hit_reg    = 1'b0;
    hit_vec    = '0;
    locked     = 1'b0;
    old_val    = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      for (int r = 0; r < REGS_PER_CH; r++) begin
        if (i_wb_adr == ADR_W'(REGS_PER_CH * c + r)) begin
          hit_vec[c*REGS_PER_CH + r] = 1'b1;
          hit_reg = 1'b1;
          old_val = regs_q[c][r];
`ifdef WB_WRITE_PROTECT_EN
          if (r != REG_CTRL && regs_q[c][REG_CTRL][LOCK_BIT]) locked = 1'b1;
`endif
        end
      end
    end
  end

  wb_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .i_old    (old_val),
    .i_new    (i_wb_data),
    .i_sel    (i_wb_sel),
    .o_merged (merged)
  );

  // A status bit clears only when its data bit and owning byte lane are both set.
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_clr
    assign clr_bits[gi] = i_wb_data[gi] & i_wb_sel[gi/8];
  end

  always_comb begin
    err_d     = accept & (~(hit_reg | hit_status) | (i_wb_we & locked));
    ack_d     = accept & ~err_d;
    reg_wr    = accept & i_wb_we & hit_reg & ~locked;
    status_wr = accept & i_wb_we & hit_status;

    regs_d = regs_q;
    for (int c = 0; c < CH_NUM; c++) begin
      for (int r = 0; r < REGS_PER_CH; r++) begin
        if (reg_wr && hit_vec[c*REGS_PER_CH + r]) regs_d[c][r] = merged;
      end
    end

    // Incoming events override a same-cycle clear.
    flags_d = (flags_q & ~(status_wr ? clr_bits : '0)) | i_ch_irq;

    data_d = '0;
    if (accept && !i_wb_we) begin
      if (hit_reg)         data_d = old_val;
      else if (hit_status) data_d[CH_NUM-1:0] = flags_q;
    end

    irq_d = |flags_q;
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        for (int r = 0; r < REGS_PER_CH; r++) begin
          regs_q[c][r] <= '0;
        end
      end
      flags_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_out
    assign o_ch_ctrl  [gi*DATA_W +: DATA_W] = regs_q[gi][REG_CTRL];
    assign o_ch_period[gi*DATA_W +: DATA_W] = regs_q[gi][REG_PERIOD];
    assign o_ch_div   [gi*DATA_W +: DATA_W] = regs_q[gi][REG_DIV];
    assign o_ch_dc    [gi*DATA_W +: DATA_W] = regs_q[gi][REG_DC];
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_err  = err_q;
  assign o_wb_data = data_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_wb_regfile_mc.sv
// Directed self-checking bench for wb_regfile_mc (DATA_W=16, CH_NUM=3, ADR_W=16).
module tb_wb_regfile_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = '0;
  logic [1:0]  sel = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  irq = '0;
  logic        ack, err, o_irq;
  logic [15:0] rdata;
  logic [47:0] o_ch_ctrl, o_ch_period, o_ch_div, o_ch_dc;

  int total = 0;
  int bad   = 0;

  // Values seen in the response cycle and in the cycle after it.
  logic        r_ack, r_err, n_ack, n_err;
  logic [15:0] r_data, n_data;
  logic [47:0] r_period, r_div;

  wb_regfile_mc #(.DATA_W(16), .CH_NUM(3), .ADR_W(16)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_data(wdata), .i_ch_irq(irq),
    .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata),
    .o_ch_ctrl(o_ch_ctrl), .o_ch_period(o_ch_period), .o_ch_div(o_ch_div),
    .o_ch_dc(o_ch_dc), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic xfer(input logic w, input logic [15:0] a, input logic [1:0] s,
                      input logic [15:0] d, input logic [2:0] ev);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdata = d; irq = ev;
    @(posedge clk); #1;
    r_ack = ack; r_err = err; r_data = rdata; r_period = o_ch_period; r_div = o_ch_div;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; irq = 3'b000;
    @(posedge clk); #1;
    n_ack = ack; n_err = err; n_data = rdata;
    $display("xfer we=%0d adr=%0d sel=%b wd=%h ev=%b -> ack=%0d err=%0d rd=%h", w, a, s, d, ev, r_ack, r_err, r_data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", rdata); end
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
    total++; if ({o_ch_ctrl, o_ch_period, o_ch_div, o_ch_dc} !== 192'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {o_ch_ctrl, o_ch_period, o_ch_div, o_ch_dc}); end
    @(negedge clk); rst = 1'b0;
    for (int a = 0; a <= 12; a++) begin
      xfer(1'b0, 16'(a), 2'b11, 16'h0, 3'b000);
      total++; if (r_ack !== 1'b1) begin bad++; $display("FAIL rd_ack adr=%0d got=%b exp=1", a, r_ack); end
      total++; if (r_err !== 1'b0 || n_err !== 1'b0) begin bad++; $display("FAIL rd_err adr=%0d got=%b%b exp=00", a, r_err, n_err); end
      total++; if (r_data !== 16'h0) begin bad++; $display("FAIL rd_data adr=%0d got=%h exp=0000", a, r_data); end
      total++; if (n_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse adr=%0d got=%b exp=0", a, n_ack); end
    end
  endtask

  task automatic test_full_write();
    xfer(1'b1, 16'd5, 2'b11, 16'hBEEF, 3'b000);
    total++; if (r_ack !== 1'b1) begin bad++; $display("FAIL wr5_ack got=%b exp=1", r_ack); end
    total++; if (r_period[31:16] !== 16'hBEEF) begin bad++; $display("FAIL wr5_period_ack_cycle got=%h exp=beef", r_period[31:16]); end
    xfer(1'b0, 16'd5, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'hBEEF) begin bad++; $display("FAIL rd5_data got=%h exp=beef", r_data); end
    total++; if (n_data !== 16'h0) begin bad++; $display("FAIL rd5_data_after got=%h exp=0000", n_data); end
  endtask

  task automatic test_byte_lanes();
    xfer(1'b1, 16'd2, 2'b11, 16'hBEEF, 3'b000);
    xfer(1'b1, 16'd2, 2'b01, 16'h1234, 3'b000);
    total++; if (o_ch_div[15:0] !== 16'hBE34) begin bad++; $display("FAIL lane0_div got=%h exp=be34", o_ch_div[15:0]); end
    xfer(1'b1, 16'd2, 2'b10, 16'h5600, 3'b000);
    total++; if (o_ch_div[15:0] !== 16'h5634) begin bad++; $display("FAIL lane1_div got=%h exp=5634", o_ch_div[15:0]); end
    xfer(1'b1, 16'd2, 2'b00, 16'hFFFF, 3'b000);
    total++; if (r_ack !== 1'b1) begin bad++; $display("FAIL sel0_ack got=%b exp=1", r_ack); end
    total++; if (o_ch_div[15:0] !== 16'h5634) begin bad++; $display("FAIL sel0_div got=%h exp=5634", o_ch_div[15:0]); end
    xfer(1'b0, 16'd2, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'h5634) begin bad++; $display("FAIL rd2_data got=%h exp=5634", r_data); end
  endtask

  task automatic test_unmapped();
    xfer(1'b0, 16'd13, 2'b11, 16'h0, 3'b000);
    total++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin bad++; $display("FAIL rd13_resp got=ack%b err%b exp=ack0 err1", r_ack, r_err); end
    total++; if (r_data !== 16'h0) begin bad++; $display("FAIL rd13_data got=%h exp=0000", r_data); end
    total++; if (n_err !== 1'b0) begin bad++; $display("FAIL rd13_err_pulse got=%b exp=0", n_err); end
    xfer(1'b1, 16'd13, 2'b11, 16'hFFFF, 3'b000);
    total++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin bad++; $display("FAIL wr13_resp got=ack%b err%b exp=ack0 err1", r_ack, r_err); end
    xfer(1'b1, 16'hFFFF, 2'b11, 16'hFFFF, 3'b000);
    total++; if (r_err !== 1'b1) begin bad++; $display("FAIL wrffff_err got=%b exp=1", r_err); end
    total++; if (o_ch_period !== 48'h0000_BEEF_0000 || o_ch_div !== 48'h0000_0000_5634) begin bad++; $display("FAIL unmapped_nochange got=%h/%h exp=0000beef0000/000000005634", o_ch_period, o_ch_div); end
    total++; if (o_ch_ctrl !== 48'h0 || o_ch_dc !== 48'h0 || o_irq !== 1'b0) begin bad++; $display("FAIL unmapped_nochange2 got=%h/%h/%b exp=0/0/0", o_ch_ctrl, o_ch_dc, o_irq); end
  endtask

  task automatic test_status();
    @(negedge clk); irq = 3'b101;
    @(posedge clk); #1; irq = 3'b000;
    @(posedge clk); #1;
    total++; if (o_irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", o_irq); end
    xfer(1'b0, 16'd12, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'h0005) begin bad++; $display("FAIL status_101 got=%h exp=0005", r_data); end
    xfer(1'b1, 16'd12, 2'b11, 16'h0001, 3'b001);
    total++; if (r_ack !== 1'b1) begin bad++; $display("FAIL w1c_ack got=%b exp=1", r_ack); end
    xfer(1'b0, 16'd12, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'h0005) begin bad++; $display("FAIL set_wins got=%h exp=0005", r_data); end
    xfer(1'b1, 16'd12, 2'b11, 16'h0005, 3'b000);
    total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", o_irq); end
    xfer(1'b0, 16'd12, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'h0000) begin bad++; $display("FAIL status_clear got=%h exp=0000", r_data); end
    @(negedge clk); irq = 3'b010;
    @(posedge clk); #1; irq = 3'b000;
    xfer(1'b1, 16'd12, 2'b10, 16'h0002, 3'b000);
    xfer(1'b1, 16'd12, 2'b11, 16'hFFF8, 3'b000);
    xfer(1'b0, 16'd12, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'h0002) begin bad++; $display("FAIL w1c_lane_high_bits got=%h exp=0002", r_data); end
    xfer(1'b1, 16'd12, 2'b01, 16'h0002, 3'b000);
    xfer(1'b0, 16'd12, 2'b11, 16'h0, 3'b000);
    total++; if (r_data !== 16'h0000) begin bad++; $display("FAIL w1c_lane0 got=%h exp=0000", r_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    logic [3:0] errs;
    logic [15:0] d0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd5; sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      acks[i] = ack; errs[i] = err;
      if (i == 0) d0 = rdata;
    end
    cyc = 1'b0; stb = 1'b0;
    $display("b2b acks=%b errs=%b d0=%h", acks, errs, d0);
    total++; if (acks !== 4'b0101) begin bad++; $display("FAIL b2b_acks got=%b exp=0101", acks); end
    total++; if (errs !== 4'b0000) begin bad++; $display("FAIL b2b_errs got=%b exp=0000", errs); end
    total++; if (d0 !== 16'hBEEF) begin bad++; $display("FAIL b2b_data got=%h exp=beef", d0); end
  endtask

  task automatic test_write_protect();
    xfer(1'b1, 16'd0, 2'b11, 16'h8000, 3'b000);
    total++; if (r_ack !== 1'b1) begin bad++; $display("FAIL lock_ctrl_ack got=%b exp=1", r_ack); end
    xfer(1'b1, 16'd1, 2'b11, 16'h1111, 3'b000);
`ifdef WB_WRITE_PROTECT_EN
    total++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin bad++; $display("FAIL locked_wr got=ack%b err%b exp=ack0 err1", r_ack, r_err); end
    total++; if (o_ch_period[15:0] !== 16'h0000) begin bad++; $display("FAIL locked_period got=%h exp=0000", o_ch_period[15:0]); end
    xfer(1'b0, 16'd1, 2'b11, 16'h0, 3'b000);
    total++; if (r_ack !== 1'b1) begin bad++; $display("FAIL locked_rd_ack got=%b exp=1", r_ack); end
    xfer(1'b1, 16'd0, 2'b11, 16'h0000, 3'b000);
    xfer(1'b1, 16'd1, 2'b11, 16'h1111, 3'b000);
`endif
    total++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin bad++; $display("FAIL unlocked_wr got=ack%b err%b exp=ack1 err0", r_ack, r_err); end
    total++; if (o_ch_period[15:0] !== 16'h1111) begin bad++; $display("FAIL unlocked_period got=%h exp=1111", o_ch_period[15:0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd3; sel = 2'b11; wdata = 16'h00AA;
    @(posedge clk); #1;
    total++; if (ack !== 1'b1 || o_ch_dc[15:0] !== 16'h00AA) begin bad++; $display("FAIL mid_pre got=ack%b dc%h exp=ack1 dc00aa", ack, o_ch_dc[15:0]); end
    rst = 1'b1; #1;
    total++; if (ack !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_rst_resp got=ack%b err%b exp=00", ack, err); end
    total++; if (o_ch_dc !== 48'h0 || o_ch_period !== 48'h0) begin bad++; $display("FAIL mid_rst_regs got=%h/%h exp=0/0", o_ch_dc, o_ch_period); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    $display("reset mid-transfer done");
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_unmapped();
    test_status();
    test_back_to_back();
    test_write_protect();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
